// File: rtl/multireg_pkg.sv
// rtl/multireg_pkg.sv - shared types for the three-register bank write master
package multireg_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    SEL_A   = 2'd0,
    SEL_B   = 2'd1,
    SEL_C   = 2'd2,
    SEL_ALL = 2'd3
  } reg_sel_e;

  typedef struct packed {
    reg_sel_e              sel;
    logic [DATA_W-1:0]     data;
  } wr_req_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2
  } fsm_state_e;

  // Enable vector ordering is {C_EN, B_EN, A_EN}
  function automatic logic [2:0] sel_to_en(reg_sel_e sel);
    case (sel)
      SEL_A:   return 3'b001;
      SEL_B:   return 3'b010;
      SEL_C:   return 3'b100;
      default: return 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/multireg_bus_writer_if.sv
// rtl/multireg_bus_writer_if.sv - valid/ready write-request channel into the bank writer
interface multireg_bus_writer_if;

  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_addr;
  logic [7:0] req_data;

  modport master (output req_valid, output req_addr, output req_data, input req_ready);
  modport slave  (input req_valid, input req_addr, input req_data, output req_ready);

endinterface

// File: rtl/multireg_bus_writer_sync_fifo.sv
// rtl/multireg_bus_writer_sync_fifo.sv - synchronous FIFO with occupancy count, head visible on rd_data
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push  = push && !full;
  assign w_pop   = pop && !empty;
  assign full    = (r_count == LW'(DEPTH));
  assign empty   = (r_count == '0);
  assign level   = r_count;
  assign rd_data = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // DEPTH is a power of two, so pointers wrap naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + LW'(1);
        2'b01:   r_count <= r_count - LW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/multireg_bus_writer.sv
// rtl/multireg_bus_writer.sv - queued write master for the A/B/C register bank
// Broadcast writes (addr 3) are enabled by defining MULTIREG_BCAST_EN.
module multireg_bus_writer
  import multireg_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int SETUP_CYCLES = 1
) (
  input  logic                         Clock,
  input  logic                         Reset,
  multireg_bus_writer_if.slave         req,
  output logic [DATA_W-1:0]            Data_Bus,
  output logic                         A_EN,
  output logic                         B_EN,
  output logic                         C_EN,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         drop_err
);

  localparam logic [2:0] SETUP_INIT = (SETUP_CYCLES == 0) ? 3'd0 : 3'(SETUP_CYCLES - 1);

  wr_req_t           w_in;
  wr_req_t           w_head;
  logic              w_full;
  logic              w_empty;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;

  fsm_state_e        r_state;
  logic [2:0]        r_cnt;
  reg_sel_e          r_sel;
  logic [DATA_W-1:0] r_data;
  logic [2:0]        r_en;
  logic              r_drop;

  assign req.req_ready = !w_full;
  assign w_accept      = req.req_valid && !w_full;
  assign w_in          = '{sel: reg_sel_e'(req.req_addr), data: req.req_data};

`ifdef MULTIREG_BCAST_EN
  assign w_push = w_accept;
`else
  // Broadcast requests complete the handshake but are never queued
  assign w_push = w_accept && (reg_sel_e'(req.req_addr) != SEL_ALL);
`endif

  assign w_pop = !w_empty && ((r_state == IDLE) || (r_state == STROBE));

  sync_fifo #(
    .WIDTH ($bits(wr_req_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (Clock),
    .rst     (Reset),
    .push    (w_push),
    .pop     (w_pop),
    .wr_data (w_in),
    .rd_data (w_head),
    .full    (w_full),
    .empty   (w_empty),
    .level   (level)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_sel   <= SEL_A;
      r_data  <= '0;
      r_en    <= '0;
      r_drop  <= 1'b0;
    end else begin
      r_en <= '0;
`ifdef MULTIREG_BCAST_EN
      r_drop <= 1'b0;
`else
      r_drop <= w_accept && (reg_sel_e'(req.req_addr) == SEL_ALL);
`endif
      case (r_state)
        IDLE, STROBE: begin
          if (w_pop) begin
            r_data <= w_head.data;
            r_sel  <= w_head.sel;
            if (SETUP_CYCLES == 0) begin
              r_state <= STROBE;
              r_en    <= sel_to_en(w_head.sel);
            end else begin
              r_state <= SETUP;
              r_cnt   <= SETUP_INIT;
            end
          end else begin
            r_state <= IDLE;
          end
        end
        SETUP: begin
          if (r_cnt == 3'd0) begin
            r_state <= STROBE;
            r_en    <= sel_to_en(r_sel);
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign Data_Bus = r_data;
  assign A_EN     = r_en[0];
  assign B_EN     = r_en[1];
  assign C_EN     = r_en[2];
  assign busy     = !w_empty || (r_state != IDLE);
  assign drop_err = r_drop;

endmodule

// File: tb/tb_multireg_bus_writer.sv
// tb/tb_multireg_bus_writer.sv - directed bench for multireg_bus_writer (SETUP_CYCLES=1 and 0 instances)
module tb_multireg_bus_writer;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  always #5 Clock = ~Clock;

  multireg_bus_writer_if bus1 ();
  multireg_bus_writer_if bus0 ();

  logic [7:0] db1, db0;
  logic       a1, b1, c1, a0, b0, c0;
  logic       busy1, busy0, drop1, drop0;
  logic [2:0] lvl1, lvl0;
  logic [2:0] en1, en0;

  assign en1 = {c1, b1, a1};
  assign en0 = {c0, b0, a0};

  multireg_bus_writer #(.DEPTH(4), .SETUP_CYCLES(1)) u_dut1 (
    .Clock (Clock), .Reset (Reset), .req (bus1.slave), .Data_Bus (db1),
    .A_EN (a1), .B_EN (b1), .C_EN (c1), .busy (busy1), .level (lvl1), .drop_err (drop1)
  );

  multireg_bus_writer #(.DEPTH(4), .SETUP_CYCLES(0)) u_dut0 (
    .Clock (Clock), .Reset (Reset), .req (bus0.slave), .Data_Bus (db0),
    .A_EN (a0), .B_EN (b0), .C_EN (c0), .busy (busy0), .level (lvl0), .drop_err (drop0)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int drops1 = 0;
  logic [10:0] mon1 [$];
  logic [10:0] mon0 [$];
  int          mon0_cyc [$];
  logic [7:0]  bank_a = 8'h00, bank_b = 8'h00, bank_c = 8'h00;

  always @(posedge Clock) begin
    cyc++;
    if (a1) bank_a <= db1;
    if (b1) bank_b <= db1;
    if (c1) bank_c <= db1;
  end

  always @(negedge Clock) begin
    if (en1 != 3'b000) mon1.push_back({en1, db1});
    if (drop1) drops1++;
    if (en0 != 3'b000) begin
      mon0.push_back({en0, db0});
      mon0_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic push1(input logic [1:0] addr, input logic [7:0] data);
    int guard;
    bus1.req_valid = 1'b1;
    bus1.req_addr  = addr;
    bus1.req_data  = data;
    guard = 0;
    while (!bus1.req_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) check("push_ready_timeout", bus1.req_ready, 1);
    tick();
  endtask

  task automatic wait_idle1(input string tag);
    int guard;
    guard = 0;
    while (busy1 && guard < 100) begin
      tick();
      guard++;
    end
    check(tag, busy1, 0);
  endtask

  logic [10:0] exp_fill [7];
  logic [10:0] exp_b2b  [3];

  initial begin
    exp_fill = '{{3'b001, 8'h11}, {3'b010, 8'h22}, {3'b100, 8'h33}, {3'b001, 8'h44},
                 {3'b010, 8'h55}, {3'b100, 8'h66}, {3'b010, 8'h55}};
    exp_b2b  = '{{3'b001, 8'h01}, {3'b010, 8'h02}, {3'b100, 8'h03}};
    bus1.req_valid = 1'b0; bus1.req_addr = 2'd0; bus1.req_data = 8'h00;
    bus0.req_valid = 1'b0; bus0.req_addr = 2'd0; bus0.req_data = 8'h00;

    // Reset state
    Reset = 1'b1;
    tick(); tick();
    Reset = 1'b0;
    check("rst_data_bus", db1, 8'h00);
    check("rst_en", en1, 3'b000);
    check("rst_level", lvl1, 0);
    check("rst_busy", busy1, 0);
    check("rst_drop", drop1, 0);
    check("rst_ready", bus1.req_ready, 1);
    tick();

    // Single write, B=5A, SETUP_CYCLES=1
    mon1.delete();
    bus1.req_valid = 1'b1; bus1.req_addr = 2'd1; bus1.req_data = 8'h5A;
    tick();
    bus1.req_valid = 1'b0;
    check("single_level_N", lvl1, 1);
    check("single_busy_N", busy1, 1);
    check("single_en_N", en1, 3'b000);
    tick();
    check("single_bus_N1", db1, 8'h5A);
    check("single_en_N1", en1, 3'b000);
    tick();
    check("single_en_N2", en1, 3'b010);
    check("single_bus_N2", db1, 8'h5A);
    tick();
    check("single_en_N3", en1, 3'b000);
    check("single_busy_N3", busy1, 0);
    check("single_bank_b", bank_b, 8'h5A);
    check("single_strobes", mon1.size(), 1);

    // Fill / backpressure, then push into a full FIFO while STROBE pops
    mon1.delete();
    drops1 = 0;
    push1(2'd0, 8'h11);
    push1(2'd1, 8'h22);
    push1(2'd2, 8'h33);
    push1(2'd0, 8'h44);
    push1(2'd1, 8'h55);
    push1(2'd2, 8'h66);
    check("fill_ready_before_7th", bus1.req_ready, 1);
    check("fill_level_before_7th", lvl1, 3);
    push1(2'd1, 8'h55);
    bus1.req_valid = 1'b1;
    check("full_level", lvl1, 4);
    check("full_ready", bus1.req_ready, 0);
    check("full_strobe_c", en1, 3'b100);
    tick();
    bus1.req_valid = 1'b0;
    check("full_pop_level", lvl1, 3);
    check("full_pop_ready", bus1.req_ready, 1);
    wait_idle1("fill_idle_timeout");
    tick();
    check("fill_count", mon1.size(), 7);
    for (int i = 0; i < 7; i++) begin
      check($sformatf("fill_strobe_%0d", i), (i < mon1.size()) ? mon1[i] : 11'h000, exp_fill[i]);
    end
    check("fill_bank_a", bank_a, 8'h44);
    check("fill_bank_b", bank_b, 8'h55);
    check("fill_bank_c", bank_c, 8'h66);
    check("fill_no_drop", drops1, 0);

    // Back-to-back on the SETUP_CYCLES=0 instance
    mon0.delete();
    mon0_cyc.delete();
    bus0.req_valid = 1'b1; bus0.req_addr = 2'd0; bus0.req_data = 8'h01;
    tick();
    bus0.req_addr = 2'd1; bus0.req_data = 8'h02;
    tick();
    bus0.req_addr = 2'd2; bus0.req_data = 8'h03;
    tick();
    bus0.req_valid = 1'b0;
    repeat (4) tick();
    check("b2b_count", mon0.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("b2b_strobe_%0d", i), (i < mon0.size()) ? mon0[i] : 11'h000, exp_b2b[i]);
    end
    if (mon0_cyc.size() == 3) begin
      check("b2b_gap_0", mon0_cyc[1] - mon0_cyc[0], 1);
      check("b2b_gap_1", mon0_cyc[2] - mon0_cyc[1], 1);
    end
    check("b2b_busy", busy0, 0);

    // Broadcast
    mon1.delete();
    drops1 = 0;
    bus1.req_valid = 1'b1; bus1.req_addr = 2'd3; bus1.req_data = 8'hFF;
    tick();
    bus1.req_valid = 1'b0;
`ifdef MULTIREG_BCAST_EN
    check("bcast_level", lvl1, 1);
    check("bcast_drop", drop1, 0);
    wait_idle1("bcast_idle_timeout");
    tick();
    check("bcast_count", mon1.size(), 1);
    check("bcast_strobe", (mon1.size() > 0) ? mon1[0] : 11'h000, {3'b111, 8'hFF});
    check("bcast_bank_a", bank_a, 8'hFF);
    check("bcast_bank_c", bank_c, 8'hFF);
`else
    check("bcast_drop_pulse", drop1, 1);
    check("bcast_level", lvl1, 0);
    check("bcast_busy", busy1, 0);
    tick();
    check("bcast_drop_clear", drop1, 0);
    repeat (4) tick();
    check("bcast_no_strobe", mon1.size(), 0);
    check("bcast_drop_count", drops1, 1);
    check("bcast_bank_a", bank_a, 8'h44);
`endif

    // Reset mid-stream with queued writes
    push1(2'd0, 8'hAA);
    push1(2'd1, 8'hBB);
    push1(2'd2, 8'hCC);
    bus1.req_valid = 1'b0;
    Reset = 1'b1;
    tick(); tick();
    Reset = 1'b0;
    check("midrst_data_bus", db1, 8'h00);
    check("midrst_en", en1, 3'b000);
    check("midrst_level", lvl1, 0);
    check("midrst_busy", busy1, 0);
    mon1.delete();
    tick();
    check("midrst_en_next", en1, 3'b000);
    check("midrst_bus_next", db1, 8'h00);
    repeat (8) tick();
    check("midrst_no_strobe", mon1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
